// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider answering the execute-stage divide
// handshake. One quotient bit per cycle; result packed {remainder, quotient}.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   divisor_reg, divisor_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  // The shifted remainder is below 2*divisor, so bit WIDTH of the
  // (WIDTH+1)-bit difference is set exactly when the subtract borrows.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             op1_neg;
  logic             op2_neg;

  assign rem_sh   = {rem_reg, quo_reg[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, divisor_reg};
  assign borrow   = diff[WIDTH];
  assign rem_step = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], ~borrow};
  assign op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg  = signed_div_i & opdata2_i[WIDTH-1];

  // Next-state and datapath decisions for the divide sequence.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    divisor_next = divisor_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;
    unique case (state_reg)
      FREE: begin
        if (start_i && !annul_i) begin
          state_next   = (opdata2_i == '0) ? BY_ZERO : ON;
          neg_q_next   = op1_neg ^ op2_neg;
          neg_r_next   = op1_neg;
          quo_next     = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
          divisor_next = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
          rem_next     = '0;
          cnt_next     = '0;
        end
      end
      BY_ZERO: begin
        state_next = END;
        rem_next   = '0;
        quo_next   = '0;
      end
      ON: begin
        if (annul_i) begin
          state_next = FREE;
        end else begin
          rem_next = rem_step;
          quo_next = quo_step;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            // Last step: fold the sign correction into the same edge.
            state_next = END;
            quo_next   = neg_q_reg ? (~quo_step + 1'b1) : quo_step;
            rem_next   = neg_r_reg ? (~rem_step + 1'b1) : rem_step;
          end
        end
      end
      END: begin
        result_next = {rem_reg, quo_reg};
        ready_next  = start_i;
        if (!start_i) begin
          state_next = FREE;
        end
      end
      default: state_next = FREE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= FREE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rem_reg     <= rem_next;
      quo_reg     <= quo_next;
      divisor_reg <= divisor_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_radix2.sv
// Bench for div_radix2: a cycle-count model of the handshake plus plain
// arithmetic for the results, checked every cycle, and directed vectors
// with literal expected results and latencies.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_radix2 #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Expected {remainder, quotient} from ordinary arithmetic.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshake model: counts edges since the accepted start instead of
  // tracking any internal state.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_bz = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pend = 64'h0;
  logic [63:0] m_result = 64'h0;
  logic        m_ready = 1'b0;

  always @(posedge clk) begin
    int left;
    left = m_left - 1;
    if (!rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_ready  <= 1'b0;
      m_result <= 64'h0;
    end else if (m_done) begin
      if (!start_i) begin
        m_done  <= 1'b0;
        m_ready <= 1'b0;
      end
    end else if (m_busy) begin
      if (annul_i && !m_bz && m_left >= 2) begin
        m_busy <= 1'b0;
      end else begin
        m_left <= left;
        if (left == 0) begin
          m_busy   <= 1'b0;
          m_result <= m_pend;
          m_ready  <= start_i;
          m_done   <= start_i;
        end
      end
    end else if (start_i && !annul_i) begin
      m_busy <= 1'b1;
      m_bz   <= (opdata2_i == 32'h0);
      m_left <= (opdata2_i == 32'h0) ? 2 : 33;
      m_pend <= model_div(opdata1_i, opdata2_i, signed_div_i);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_ready", {63'h0, ready_o}, {63'h0, m_ready});
    chk("cyc_result", result_o, m_result);
  end

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input int lat);
    int  cyc;
    bit  got;
    chk({"model_", name}, model_div(a, b, s), exp);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    cyc = -1;
    got = 1'b0;
    for (int i = 0; i < 45 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 0) begin
        // Operands change after the start edge; the divider must ignore it.
        opdata1_i    = ~a;
        opdata2_i    = b + 32'd3;
        signed_div_i = ~s;
      end
      if (ready_o) got = 1'b1;
    end
    chk({"lat_", name}, 64'(got ? cyc : -1), 64'(lat));
    chk({"res_", name}, result_o, exp);
    $display("[TB] %s a=%h b=%h signed=%0d result=%h latency=%0d", name, a, b, s, result_o, cyc);
    repeat (2) @(negedge clk);
    chk({"hold_", name}, {63'h0, ready_o}, 64'h1);
    start_i = 1'b0;
    @(negedge clk);
    chk({"drop_", name}, {63'h0, ready_o}, 64'h0);
  endtask

  initial begin
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'h0, ready_o}, 64'h0);
    chk("reset_result", result_o, 64'h0);
    rst = 1'b1;

    run_div("u7d2",      32'd7,          32'd2,          1'b0, 64'h00000001_00000003, 33);
    run_div("sm7d2",     32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("s7dm2",     32'd7,          32'hFFFF_FFFE,  1'b1, 64'h00000001_FFFFFFFD, 33);
    run_div("umaxd16",   32'hFFFF_FFFF,  32'h10,         1'b0, 64'h0000000F_0FFFFFFF, 33);
    run_div("sovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, 33);
    run_div("div0",      32'd5,          32'd0,          1'b0, 64'h00000000_00000000, 2);

    // annul_i in FREE blocks a start.
    @(negedge clk);
    opdata1_i = 32'd20; opdata2_i = 32'd4; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("annul_free", {63'h0, ready_o}, 64'h0);
    start_i = 1'b0; annul_i = 1'b0;

    // Annul at ON cycle 10: no completion, result keeps its old value.
    run_div("u40d7", 32'd40, 32'd7, 1'b0, 64'h00000005_00000005, 33);
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("annul_ready", {63'h0, ready_o}, 64'h0);
    chk("annul_result", result_o, 64'h00000005_00000005);
    run_div("u100d7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);

    // Reset in the middle of a divide.
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (16) @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'h0, ready_o}, 64'h0);
    chk("midrst_result", result_o, 64'h0);
    rst = 1'b1;
    run_div("u9d3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
